// File: rtl/baccarat_pkg.sv
// Shared definitions for the baccarat control path.
//
// Contents:
//   state_e          sequencer state encoding. 4 bits; codes 10..15 are illegal and recover to S_P1.
//   NATURAL_MIN      two-card score at or above which the hand is a natural
//   PLAYER_DRAW_MAX  highest score at which the player (or a lone banker) draws
//   BANKER_STAND     banker score at which the banker always stands
//   FACE_MIN         lowest rank counting as zero (10, J, Q, K)
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_P1     = 4'd0,
    S_D1     = 4'd1,
    S_P2     = 4'd2,
    S_D2     = 4'd3,
    S_EVAL   = 4'd4,
    S_P3     = 4'd5,
    S_EVAL_B = 4'd6,
    S_D3     = 4'd7,
    S_RESULT = 4'd8,
    S_DONE   = 4'd9
  } state_e;

  localparam int unsigned NATURAL_MIN     = 8;
  localparam int unsigned PLAYER_DRAW_MAX = 5;
  localparam int unsigned BANKER_STAND    = 7;
  localparam int unsigned FACE_MIN        = 10;

endpackage

// File: rtl/banker_draw_rule.sv
// Banker third-card tableau, used once the player has drawn a third card.
//
// Ports:
//   dscore  in  SCORE_W  banker two-card score
//   pcard3  in  CARD_W   player third-card rank (0..13; 10..13 count as 0)
//   draw    out 1        banker takes a third card
//
// Purely combinational.
module banker_draw_rule
  import baccarat_pkg::*;
#(
  parameter int unsigned SCORE_W = 4,
  parameter int unsigned CARD_W  = 4
) (
  input  logic [SCORE_W-1:0] dscore,
  input  logic [CARD_W-1:0]  pcard3,
  output logic               draw
);

  localparam logic [CARD_W-1:0]  FACE  = CARD_W'(FACE_MIN);
  localparam logic [SCORE_W-1:0] STAND = SCORE_W'(BANKER_STAND);

  // Card value of the player's third card (faces count as zero).
  logic [CARD_W-1:0] v;

  always_comb begin
    v    = (pcard3 >= FACE) ? '0 : pcard3;
    draw = 1'b0;
    if (dscore >= STAND) begin
      draw = 1'b0;
    end else if (dscore <= SCORE_W'(2)) begin
      draw = 1'b1;
    end else if (dscore == SCORE_W'(3)) begin
      draw = (v != CARD_W'(8));
    end else if (dscore == SCORE_W'(4)) begin
      draw = (v >= CARD_W'(2)) && (v <= CARD_W'(7));
    end else if (dscore == SCORE_W'(5)) begin
      draw = (v >= CARD_W'(4)) && (v <= CARD_W'(7));
    end else begin
      // Only score 6 remains here.
      draw = (v == CARD_W'(6)) || (v == CARD_W'(7));
    end
  end

endmodule

// File: rtl/baccarat_sequencer.sv
// Control FSM for the baccarat card/score datapath. Deals one hand per reset.
//
// Ports:
//   slow_clock        in   FSM clock; the datapath captures a card on the edge leaving a load state
//   resetb            in   asynchronous active-low reset, shared with the datapath
//   pscore, dscore    in   live player/banker scores from the datapath
//   pcard3            in   player third-card rank from the datapath
//   load_pcard1..3    out  player card load strobes (one-cycle, Moore)
//   load_dcard1..3    out  banker card load strobes (one-cycle, Moore)
//   player_win_light  out  player wins (both lights = tie)
//   dealer_win_light  out  banker wins
//   done              out  hand complete; outputs frozen until reset
module baccarat_sequencer
  import baccarat_pkg::*;
#(
  parameter int unsigned SCORE_W = 4,
  parameter int unsigned CARD_W  = 4
) (
  input  logic               slow_clock,
  input  logic               resetb,
  input  logic [SCORE_W-1:0] pscore,
  input  logic [SCORE_W-1:0] dscore,
  input  logic [CARD_W-1:0]  pcard3,
  output logic               load_pcard1,
  output logic               load_pcard2,
  output logic               load_pcard3,
  output logic               load_dcard1,
  output logic               load_dcard2,
  output logic               load_dcard3,
  output logic               player_win_light,
  output logic               dealer_win_light,
  output logic               done
);

  localparam logic [SCORE_W-1:0] NAT_MIN  = SCORE_W'(NATURAL_MIN);
  localparam logic [SCORE_W-1:0] DRAW_MAX = SCORE_W'(PLAYER_DRAW_MAX);

  // Held as plain logic so unused encodings are representable and can be recovered.
  logic [3:0] state_q, state_d;
  logic       pwin_q, pwin_d;
  logic       dwin_q, dwin_d;
  logic       banker_draw;
  logic       natural;

  banker_draw_rule #(
    .SCORE_W(SCORE_W),
    .CARD_W (CARD_W)
  ) u_banker_draw_rule (
    .dscore(dscore),
    .pcard3(pcard3),
    .draw  (banker_draw)
  );

  assign natural = (pscore >= NAT_MIN) || (dscore >= NAT_MIN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_P1:     state_d = S_D1;
      S_D1:     state_d = S_P2;
      S_P2:     state_d = S_D2;
      S_D2:     state_d = S_EVAL;
      S_EVAL: begin
        if (natural) begin
          state_d = S_RESULT;
        end else if (pscore <= DRAW_MAX) begin
          state_d = S_P3;
        end else if (dscore <= DRAW_MAX) begin
          // Player stood on 6/7; banker follows the simple draw-on-5-or-less rule.
          state_d = S_D3;
        end else begin
          state_d = S_RESULT;
        end
      end
      S_P3:     state_d = S_EVAL_B;
      S_EVAL_B: state_d = banker_draw ? S_D3 : S_RESULT;
      S_D3:     state_d = S_RESULT;
      S_RESULT: state_d = S_DONE;
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_P1;
    endcase
  end

  // Lights latch on the edge leaving S_RESULT, when both scores are final.
  always_comb begin
    pwin_d = pwin_q;
    dwin_d = dwin_q;
    if (state_q == S_RESULT) begin
      pwin_d = (pscore >= dscore);
      dwin_d = (dscore >= pscore);
    end else if (state_q == S_P1) begin
      // Covers recovery from an illegal encoding: a fresh hand starts dark.
      pwin_d = 1'b0;
      dwin_d = 1'b0;
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_P1;
      pwin_q  <= 1'b0;
      dwin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pwin_q  <= pwin_d;
      dwin_q  <= dwin_d;
    end
  end

  always_comb begin
    load_pcard1 = 1'b0;
    load_pcard2 = 1'b0;
    load_pcard3 = 1'b0;
    load_dcard1 = 1'b0;
    load_dcard2 = 1'b0;
    load_dcard3 = 1'b0;
    case (state_q)
      S_P1:    load_pcard1 = 1'b1;
      S_D1:    load_dcard1 = 1'b1;
      S_P2:    load_pcard2 = 1'b1;
      S_D2:    load_dcard2 = 1'b1;
      S_P3:    load_pcard3 = 1'b1;
      S_D3:    load_dcard3 = 1'b1;
      default: ;
    endcase
  end

  assign done             = (state_q == S_DONE);
  assign player_win_light = pwin_q;
  assign dealer_win_light = dwin_q;

endmodule

// File: tb/tb_baccarat_sequencer.sv
// Self-checking bench for baccarat_sequencer. A small datapath model deals cards from a
// bench-chosen deck; a forced mode drives scores directly for rule sweeps.
module tb_baccarat_sequencer;

  logic slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  logic       resetb;
  logic [3:0] pscore, dscore, pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light, done;

  baccarat_sequencer #(
    .SCORE_W(4),
    .CARD_W (4)
  ) dut (
    .slow_clock      (slow_clock),
    .resetb          (resetb),
    .pscore          (pscore),
    .dscore          (dscore),
    .pcard3          (pcard3),
    .load_pcard1     (load_pcard1),
    .load_pcard2     (load_pcard2),
    .load_pcard3     (load_pcard3),
    .load_dcard1     (load_dcard1),
    .load_dcard2     (load_dcard2),
    .load_dcard3     (load_dcard3),
    .player_win_light(player_win_light),
    .dealer_win_light(dealer_win_light),
    .done            (done)
  );

  int checks;
  int errors;

  // ---------------- datapath model / forced inputs ----------------
  logic       force_mode;
  logic [3:0] f_ps, f_ds, f_pc3;
  logic [3:0] deck [6];  // 0:P1 1:D1 2:P2 3:D2 4:P3 5:D3
  logic [5:0] dp_loaded;
  logic [5:0] strb;
  int         dp_p, dp_d;

  assign strb = {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) dp_loaded <= '0;
    else         dp_loaded <= dp_loaded | strb;
  end

  function automatic int cval(input int r);
    return (r >= 10) ? 0 : r;
  endfunction

  always_comb begin
    dp_p = 0;
    dp_d = 0;
    if (dp_loaded[0]) dp_p += cval(int'(deck[0]));
    if (dp_loaded[2]) dp_p += cval(int'(deck[2]));
    if (dp_loaded[4]) dp_p += cval(int'(deck[4]));
    if (dp_loaded[1]) dp_d += cval(int'(deck[1]));
    if (dp_loaded[3]) dp_d += cval(int'(deck[3]));
    if (dp_loaded[5]) dp_d += cval(int'(deck[5]));
  end

  assign pscore = force_mode ? f_ps : 4'(dp_p % 10);
  assign dscore = force_mode ? f_ds : 4'(dp_d % 10);
  assign pcard3 = force_mode ? f_pc3 : (dp_loaded[4] ? deck[4] : 4'd0);

  // ---------------- reference model ----------------
  // Banker tableau as "which player third-card values make the banker draw", per banker score.
  function automatic bit banker_takes(input int d, input int pv);
    bit [9:0] m;
    case (d)
      0, 1, 2: m = 10'b11_1111_1111;
      3:       m = 10'b10_1111_1111;
      4:       m = 10'b00_1111_1100;
      5:       m = 10'b00_1111_0000;
      6:       m = 10'b00_1100_0000;
      default: m = 10'b00_0000_0000;
    endcase
    return m[pv];
  endfunction

  // Whole hand: expected strobe order (octal digits 1..6), edges to done, final lights.
  function automatic void model(input int p, input int d, input int pv, input int padd,
                                input int dadd, input bit use_deck, output int seq,
                                output int edges, output bit pw, output bit dw);
    bit pd, dd;
    pd = 1'b0;
    dd = 1'b0;
    if (p < 8 && d < 8) begin
      if (p <= 5) begin
        pd = 1'b1;
        dd = banker_takes(d, pv);
      end else begin
        dd = (d <= 5);
      end
    end
    if (use_deck) begin
      if (pd) p = (p + padd) % 10;
      if (dd) d = (d + dadd) % 10;
    end
    seq = 'o1234;
    if (pd) seq = seq * 8 + 5;
    if (dd) seq = seq * 8 + 6;
    edges = 6 + (pd ? 2 : 0) + (dd ? 1 : 0);
    pw = (p >= d);
    dw = (d >= p);
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int strobe_code(input logic [5:0] s);
    if ($countones(s) > 1) return 7;
    for (int i = 0; i < 6; i++) if (s[i]) return i + 1;
    return 0;
  endfunction

  int obs_seq;
  int done_edge;

  // Resets, releases on a falling edge, then records every strobe seen until done (bounded).
  task automatic run_hand();
    int code;
    resetb    = 1'b0;
    obs_seq   = 0;
    done_edge = -1;
    @(negedge slow_clock);
    resetb = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      code = strobe_code(strb);
      if (code != 0) obs_seq = obs_seq * 8 + code;
      if (done === 1'b1) begin
        done_edge = k;
        break;
      end
      @(negedge slow_clock);
    end
  endtask

  task automatic check_hand(input string name, input int seq, input int edges, input bit pw,
                            input bit dw);
    check({name, ".seq"}, obs_seq, seq);
    check({name, ".done_edge"}, done_edge, edges);
    check({name, ".pwin"}, {31'd0, player_win_light}, {31'd0, pw});
    check({name, ".dwin"}, {31'd0, dealer_win_light}, {31'd0, dw});
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0] ps;
    logic [3:0] ds;
    logic [3:0] pc3;
    bit         p3;
    bit         d3;
    int         edges;
    bit         pw;
    bit         dw;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int  seq, edges, p, d;
    bit  pw, dw, seen;

    checks     = 0;
    errors     = 0;
    resetb     = 1'b0;
    force_mode = 1'b1;
    f_ps       = 4'd0;
    f_ds       = 4'd0;
    f_pc3      = 4'd0;
    for (int i = 0; i < 6; i++) deck[i] = 4'd1;

    //          ps     ds     pc3    p3    d3    edges pw    dw
    vecs[0]  = '{4'd8,  4'd3, 4'd0,  1'b0, 1'b0, 6,    1'b1, 1'b0};
    vecs[1]  = '{4'd4,  4'd5, 4'd6,  1'b1, 1'b1, 9,    1'b0, 1'b1};
    vecs[2]  = '{4'd7,  4'd5, 4'd9,  1'b0, 1'b1, 7,    1'b1, 1'b0};
    vecs[3]  = '{4'd3,  4'd3, 4'd8,  1'b1, 1'b0, 8,    1'b1, 1'b1};
    vecs[4]  = '{4'd3,  4'd3, 4'd12, 1'b1, 1'b1, 9,    1'b1, 1'b1};
    vecs[5]  = '{4'd2,  4'd6, 4'd5,  1'b1, 1'b0, 8,    1'b0, 1'b1};
    vecs[6]  = '{4'd1,  4'd7, 4'd6,  1'b1, 1'b0, 8,    1'b0, 1'b1};
    vecs[7]  = '{4'd6,  4'd6, 4'd0,  1'b0, 1'b0, 6,    1'b1, 1'b1};
    vecs[8]  = '{4'd5,  4'd2, 4'd8,  1'b1, 1'b1, 9,    1'b1, 1'b0};
    vecs[9]  = '{4'd0,  4'd9, 4'd0,  1'b0, 1'b0, 6,    1'b0, 1'b1};
    vecs[10] = '{4'd12, 4'd3, 4'd0,  1'b0, 1'b0, 6,    1'b1, 1'b0};
    vecs[11] = '{4'd4,  4'd6, 4'd7,  1'b1, 1'b1, 9,    1'b0, 1'b1};
    vecs[12] = '{4'd4,  4'd4, 4'd1,  1'b1, 1'b0, 8,    1'b1, 1'b1};

    // Reset state.
    #3;
    check("reset.strobes", {26'd0, strb}, 32'd1);
    check("reset.done", {31'd0, done}, 32'd0);
    check("reset.pwin", {31'd0, player_win_light}, 32'd0);
    check("reset.dwin", {31'd0, dealer_win_light}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      f_ps  = vecs[i].ps;
      f_ds  = vecs[i].ds;
      f_pc3 = vecs[i].pc3;
      seq   = 'o1234;
      if (vecs[i].p3) seq = seq * 8 + 5;
      if (vecs[i].d3) seq = seq * 8 + 6;
      run_hand();
      check_hand($sformatf("vec%0d", i), seq, vecs[i].edges, vecs[i].pw, vecs[i].dw);
    end

    // Random forced-score hands (scores include out-of-range values).
    for (int i = 0; i < 30; i++) begin
      f_ps  = 4'($urandom_range(0, 11));
      f_ds  = 4'($urandom_range(0, 11));
      f_pc3 = 4'($urandom_range(0, 15));
      model(int'(f_ps), int'(f_ds), cval(int'(f_pc3)), 0, 0, 1'b0, seq, edges, pw, dw);
      run_hand();
      check_hand($sformatf("frc%0d", i), seq, edges, pw, dw);
    end

    // Dealt tie: player 3+4=7 stands, banker 2+3=5 draws a 2 -> 7 vs 7.
    force_mode = 1'b0;
    deck[0] = 4'd3; deck[1] = 4'd2; deck[2] = 4'd4;
    deck[3] = 4'd3; deck[4] = 4'd9; deck[5] = 4'd2;
    run_hand();
    check_hand("tie", 'o12346, 7, 1'b1, 1'b1);

    // Random dealt hands through the datapath model.
    for (int i = 0; i < 60; i++) begin
      for (int j = 0; j < 6; j++) deck[j] = 4'($urandom_range(1, 13));
      p = (cval(int'(deck[0])) + cval(int'(deck[2]))) % 10;
      d = (cval(int'(deck[1])) + cval(int'(deck[3]))) % 10;
      model(p, d, cval(int'(deck[4])), cval(int'(deck[4])), cval(int'(deck[5])), 1'b1,
            seq, edges, pw, dw);
      run_hand();
      check_hand($sformatf("deal%0d", i), seq, edges, pw, dw);
    end

    // Reset asserted while in S_P3, then a full new hand.
    force_mode = 1'b1;
    f_ps = 4'd4; f_ds = 4'd5; f_pc3 = 4'd6;
    resetb = 1'b0;
    @(negedge slow_clock);
    resetb = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge slow_clock);
      #1;
      if (load_pcard3 === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("midrst.reached_p3", {31'd0, seen}, 32'd1);
    #2 resetb = 1'b0;
    #1;
    check("midrst.strobes", {26'd0, strb}, 32'd1);
    check("midrst.done", {31'd0, done}, 32'd0);
    check("midrst.lights", {30'd0, player_win_light, dealer_win_light}, 32'd0);
    run_hand();
    check_hand("after_midrst", 'o123456, 9, 1'b0, 1'b1);

    // Reset from S_DONE clears the lit banker light at once.
    #2 resetb = 1'b0;
    #1;
    check("donerst.done", {31'd0, done}, 32'd0);
    check("donerst.lights", {30'd0, player_win_light, dealer_win_light}, 32'd0);

    // Hold in S_DONE with scores toggling: everything frozen.
    f_ps = 4'd8; f_ds = 4'd3; f_pc3 = 4'd0;
    run_hand();
    check_hand("hold_setup", 'o1234, 6, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      f_ps  = 4'($urandom_range(0, 15));
      f_ds  = 4'($urandom_range(0, 15));
      f_pc3 = 4'($urandom_range(0, 15));
      @(negedge slow_clock);
      #1;
      check($sformatf("hold%0d", k),
            {23'd0, strb, done, player_win_light, dealer_win_light}, {23'd0, 6'd0, 3'b110});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
